dmem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_array.sv | 34 +++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 tb/tb_dmem_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // A byte address is usable when it is word aligned and no bit above the
  // word-index field is set, i.e. it falls inside the 2^depth_log2-word array.
  function automatic logic mem_addr_ok(input logic [MEM_ADDR_W-1:0] addr,
                                       input int unsigned depth_log2);
    logic [MEM_ADDR_W-1:0] hi;
    hi = addr >> (depth_log2 + 2);
    return (addr[1:0] == 2'b00) && (hi == '0);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port 32-bit word array: synchronous write, combinational read.
// Latency: write lands on the clock edge, read data follows idx combinationally.
// Backpressure: none; a write is taken on every edge where we is high.
//
// Ports:
//   clk   - clock
//   we    - write enable for the word at idx
//   idx   - word index (shared by read and write)
//   wdata - write data
//   rdata - read data of word idx
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [MEM_DATA_W-1:0] wdata,
  output logic [MEM_DATA_W-1:0] rdata
);

  // Contents are deliberately left unreset.
  logic [MEM_DATA_W-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one read/write, holds it LATENCY cycles, completes with a ready pulse.
// Latency: request accepted at edge N registers ready/err/data_out at edge N+LATENCY.
// Backpressure: en is only honoured in IDLE or DONE; requests offered while busy are dropped.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous, active-low reset
//   en       - request valid
//   wr       - 1 = write, 0 = read (captured with en)
//   addr     - byte address (captured with en)
//   data_in  - write data (captured with en)
//   data_out - last successful read data
//   ready    - one-cycle completion pulse
//   err      - request rejected (only meaningful with ready)
//   busy     - request in flight
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr,
  input  logic [MEM_ADDR_W-1:0] addr,
  input  logic [MEM_DATA_W-1:0] data_in,
  output logic [MEM_DATA_W-1:0] data_out,
  output logic                  ready,
  output logic                  err,
  output logic                  busy
);

  // BUSY lasts LATENCY-1 cycles and exits when the counter reads zero,
  // so it is loaded with LATENCY-2. Unused when LATENCY is 1.
  localparam logic [7:0] CNT_LOAD = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  mem_state_t            state_q,    state_d;
  logic [7:0]            cnt_q,      cnt_d;
  logic                  wr_q,       wr_d;
  logic [MEM_ADDR_W-1:0] addr_q,     addr_d;
  logic [MEM_DATA_W-1:0] wdata_q,    wdata_d;
  logic [MEM_DATA_W-1:0] data_out_q, data_out_d;
  logic                  ready_q,    ready_d;
  logic                  err_q,      err_d;
  logic                  busy_q,     busy_d;

  logic                  accept;
  logic                  addr_ok;
  logic                  mem_we;
  logic [MEM_DATA_W-1:0] mem_rdata;

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem_array (
    .clk  (clk),
    .we   (mem_we),
    .idx  (addr_q[DEPTH_LOG2+1:2]),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    busy_d     = 1'b0;
    accept     = 1'b0;
    mem_we     = 1'b0;
    addr_ok    = mem_addr_ok(addr_q, DEPTH_LOG2);

    case (state_q)
      IDLE: begin
        accept = en;
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        // The captured access is performed on the edge leaving DONE, which
        // is also the edge a back-to-back request is accepted on; a read
        // accepted here therefore sees this cycle's write.
        ready_d = 1'b1;
        err_d   = ~addr_ok;
        if (addr_ok) begin
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            data_out_d = mem_rdata;
          end
        end
        state_d = IDLE;
        accept  = en;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      wr_d    = wr;
      addr_d  = addr;
      wdata_d = data_in;
      if (LATENCY == 1) begin
        state_d = DONE;
      end else begin
        state_d = BUSY;
        cnt_d   = CNT_LOAD;
      end
    end

    // A re-accepted request enters BUSY in the same cycle ready pulses;
    // busy is held off for that cycle so the two are never high together.
    busy_d = (state_d == BUSY) && !ready_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out = data_out_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 4 and LATENCY 1) share one
// input bus; each is compared every cycle against a transaction-level model.
// Directed steps cover the listed scenarios, followed by a random phase.
module tb_dmem_responder;

  localparam int DL2 = 10;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr;
  logic [15:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_o  [2];
  logic        ready_o [2];
  logic        err_o   [2];
  logic        busy_o  [2];

  dmem_responder #(.LATENCY(4), .DEPTH_LOG2(DL2)) u_a (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_o[0]), .ready(ready_o[0]), .err(err_o[0]), .busy(busy_o[0])
  );

  dmem_responder #(.LATENCY(1), .DEPTH_LOG2(DL2)) u_b (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_o[1]), .ready(ready_o[1]), .err(err_o[1]), .busy(busy_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  // Reference model: one pending transaction per instance, due LATENCY edges
  // after it was accepted; effects are applied to a plain word array on completion.
  int          lat     [2];
  logic        m_pend  [2];
  int          m_acc   [2];
  logic        m_wr    [2];
  int          m_addr  [2];
  logic [31:0] m_data  [2];
  logic [31:0] m_dout  [2];
  logic        m_ready [2];
  logic        m_err   [2];
  logic        m_busy  [2];
  logic [31:0] m_mem   [2][16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pv(input int i);
    return 32'h1000_0000 | (32'(i) << 8) | 32'(i);
  endfunction

  function automatic logic [15:0] rand_addr();
    int sel;
    logic [15:0] r;
    sel = $urandom_range(0, 7);
    if (sel == 0)      r = 16'(($urandom_range(0, 15) << 2) | $urandom_range(1, 3));
    else if (sel == 1) r = 16'(($urandom_range(1, 15) << 12) | ($urandom_range(0, 1023) << 2));
    else               r = 16'($urandom_range(0, 15) << 2);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k]  = 1'b0;
      m_ready[k] = 1'b0;
      m_err[k]   = 1'b0;
      m_busy[k]  = 1'b0;
      m_dout[k]  = 32'h0;
    end
  endtask

  task automatic model_edge(input int k);
    logic bad;
    m_ready[k] = 1'b0;
    m_err[k]   = 1'b0;
    if (m_pend[k] && (cyc == m_acc[k] + lat[k])) begin
      m_ready[k] = 1'b1;
      m_pend[k]  = 1'b0;
      bad = (m_addr[k] % 4 != 0) || (m_addr[k] >= 4 * (1 << DL2));
      m_err[k] = bad;
      if (!bad) begin
        if (m_wr[k]) m_mem[k][m_addr[k] / 4] = m_data[k];
        else         m_dout[k] = m_mem[k][m_addr[k] / 4];
      end
    end
    if (en && !m_pend[k]) begin
      m_pend[k] = 1'b1;
      m_acc[k]  = cyc;
      m_wr[k]   = wr;
      m_addr[k] = int'(addr);
      m_data[k] = data_in;
    end
    m_busy[k] = m_pend[k] && (cyc - m_acc[k] <= lat[k] - 2) && !m_ready[k];
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
  task automatic step(input logic e, input logic w, input logic [15:0] a, input logic [31:0] d);
    en = e; wr = w; addr = a; data_in = d;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) model_edge(k);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_ready", k), 32'(ready_o[k]), 32'(m_ready[k]));
      chk($sformatf("dut%0d_err", k),   32'(err_o[k]),   32'(m_err[k]));
      chk($sformatf("dut%0d_busy", k),  32'(busy_o[k]),  32'(m_busy[k]));
      chk($sformatf("dut%0d_dout", k),  data_o[k],       m_dout[k]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'(($urandom)), rand_addr(), $urandom);
  endtask

  // Full request on the LATENCY=4 instance (must be idle on entry). With noisy set,
  // en and the request fields are scrambled throughout its BUSY window.
  task automatic run_a(input logic w, input logic [15:0] a, input logic [31:0] d, input logic noisy);
    step(1'b1, w, a, d);
    chk("a_busy_after_accept", 32'(busy_o[0]), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      step(noisy, 1'($urandom), rand_addr(), $urandom);
      chk("a_no_early_ready", 32'(ready_o[0]), 32'd0);
    end
    step(1'b0, 1'b0, 16'h0, 32'h0);
    chk("a_ready_at_latency", 32'(ready_o[0]), 32'd1);
    chk("a_busy_with_ready", 32'(busy_o[0]), 32'd0);
  endtask

  logic        b_w [6];
  logic [31:0] b_d [6];
  int          n_rdy;

  initial begin
    lat[0] = 4;
    lat[1] = 1;
    model_reset();
    rst = 1'b0; en = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 32'h0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", 32'(ready_o[k]), 32'd0);
      chk("reset_err",   32'(err_o[k]),   32'd0);
      chk("reset_busy",  32'(busy_o[k]),  32'd0);
      chk("reset_dout",  data_o[k],       32'd0);
    end
    rst = 1'b1;

    // Known contents in the 16 words the bench touches, spaced so both instances take each write.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 16'(i * 4), pv(i));
      idle(4);
    end

    // Basic write then read.
    run_a(1'b1, 16'h0010, 32'hDEADBEEF, 1'b0);
    chk("basic_wr_err", 32'(err_o[0]), 32'd0);
    run_a(1'b0, 16'h0010, 32'h0, 1'b0);
    chk("basic_rd_err", 32'(err_o[0]), 32'd0);
    chk("basic_rd_data", data_o[0], 32'hDEADBEEF);

    // Misaligned read and write.
    run_a(1'b0, 16'h0002, 32'h0, 1'b0);
    chk("misalign_rd_err", 32'(err_o[0]), 32'd1);
    chk("misalign_rd_keep", data_o[0], 32'hDEADBEEF);
    run_a(1'b1, 16'h0006, 32'h12345678, 1'b0);
    chk("misalign_wr_err", 32'(err_o[0]), 32'd1);
    run_a(1'b0, 16'h0004, 32'h0, 1'b0);
    chk("misalign_wr_nochange", data_o[0], pv(1));

    // Out of range write.
    run_a(1'b1, 16'h1000, 32'h55AA55AA, 1'b0);
    chk("oor_wr_err", 32'(err_o[0]), 32'd1);
    run_a(1'b0, 16'h0000, 32'h0, 1'b0);
    chk("oor_rd_err", 32'(err_o[0]), 32'd0);
    chk("oor_rd_old", data_o[0], pv(0));

    // Minimum latency, en held high, alternating write/read of one word.
    for (int k = 0; k < 6; k++) begin
      b_w[k] = (k % 2 == 0);
      b_d[k] = 32'hCAFE_0000 + 32'(k);
    end
    for (int k = 0; k < 6; k++) begin
      step(1'b1, b_w[k], 16'h0004, b_d[k]);
      if (k >= 1) begin
        chk("b_ready_each_cycle", 32'(ready_o[1]), 32'd1);
        chk("b_busy_never", 32'(busy_o[1]), 32'd0);
        if (!b_w[k-1]) chk("b_raw_data", data_o[1], b_d[k-2]);
      end
    end
    step(1'b0, 1'b0, 16'h0, 32'h0);
    chk("b_last_ready", 32'(ready_o[1]), 32'd1);
    chk("b_last_raw", data_o[1], b_d[4]);
    idle(5);

    // Reset two cycles into a write.
    step(1'b1, 1'b1, 16'h0020, 32'hA5A5A5A5);
    idle(2);
    rst = 1'b0;
    #1;
    model_reset();
    chk("midrst_ready", 32'(ready_o[0]), 32'd0);
    chk("midrst_err",   32'(err_o[0]),   32'd0);
    chk("midrst_busy",  32'(busy_o[0]),  32'd0);
    chk("midrst_dout",  data_o[0],       32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(6);
    run_a(1'b0, 16'h0020, 32'h0, 1'b0);
    chk("midrst_no_commit", data_o[0], pv(8));

    // Input stability during BUSY.
    run_a(1'b1, 16'h000C, 32'h0BADF00D, 1'b1);
    chk("stable_wr_err", 32'(err_o[0]), 32'd0);
    idle(5);
    run_a(1'b0, 16'h000C, 32'h0, 1'b0);
    chk("stable_wr_data", data_o[0], 32'h0BADF00D);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom), rand_addr(), $urandom);
    end

    // Throughput with en held high on the LATENCY=4 instance.
    idle(5);
    n_rdy = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'($urandom), 16'($urandom_range(0, 15) << 2), $urandom);
      n_rdy += int'(ready_o[0]);
    end
    chk("a_throughput", 32'(n_rdy), 32'd2);
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
